hack_fetch_unit: RTL and testbench
==================================

HACK_FETCH_UNIT -- requirements
Module: hack_fetch_unit

Interface
REQ-001 The block SHALL have one clock, `clk`, and one reset, `rst`; reset is synchronous and active-high.
REQ-002 Port `clk`: input, 1 bit, rising-edge clock.
REQ-003 Port `rst`: input, 1 bit, synchronous active-high reset.
REQ-004 Port `fetch`: input, 1 bit, fetch-phase strobe from the control FSM.
REQ-005 Port `execute`: input, 1 bit, execute-phase strobe from the control FSM.
REQ-006 Port `rom_data`: input, 16 bits, instruction word read asynchronously at `rom_addr`.
REQ-007 Port `a_reg`: input, 16 bits, current A register value, used as the jump target.
REQ-008 Port `zr`: input, 1 bit, ALU output equals zero, valid during execute.
REQ-009 Port `ng`: input, 1 bit, ALU output is negative, valid during execute.
REQ-010 Port `rom_addr`: output, 15 bits, equal to `pc`.
REQ-011 Port `instr`: output, 16 bits, instruction register (IR).
REQ-012 Port `instr_valid`: output, 1 bit, IR holds a fetched word.
REQ-013 Port `jump_taken`: output, 1 bit, registered, the last execute took a jump.
REQ-014 Port `halted`: output, 1 bit, sticky flag for a self-jump.
REQ-015 Port `protocol_err`: output, 1 bit, sticky flag set when `fetch` and `execute` are asserted together.
REQ-016 Port `instr_count`: output, 16 bits, number of retired instructions.

Function
REQ-017 Internal `pc` SHALL be 15 bits; `rom_addr` SHALL be driven combinationally from `pc`, with no added latency.
REQ-018 An accepted fetch is `fetch=1`, `execute=0`, `halted=0`; at the next clock edge, IR <= `rom_data` and `instr_valid` <= 1; `pc` is unchanged.
REQ-019 An accepted execute is `execute=1`, `fetch=0`, `halted=0`, `instr_valid=1`; it retires IR at the next clock edge.
REQ-020 Jump condition: take = IR[15] & ((IR[2] & ng) | (IR[1] & zr) | (IR[0] & ~ng & ~zr)).
REQ-021 An A-instruction (IR[15]=0) SHALL never jump.
REQ-022 On an accepted execute with take=1, `pc` <= `a_reg[14:0]`; bit 15 of `a_reg` SHALL be ignored.
REQ-023 On an accepted execute with take=0, `pc` <= `pc` + 1, mod 2^15 (0x7FFF wraps to 0x0000).
REQ-024 On every accepted execute, `jump_taken` <= take; it SHALL hold its value on all other cycles.
REQ-025 On every accepted execute, `instr_count` <= `instr_count` + 1, wrapping mod 2^16.
REQ-026 If take=1 and `a_reg[14:0]` == `pc` on an accepted execute, `halted` <= 1.
REQ-027 On that halting execute, `pc` is rewritten with the same value and `instr_count` still increments.
REQ-028 While `halted`=1, all fetch and execute strobes SHALL be ignored, and IR, `pc`, `instr_count` and `jump_taken` SHALL hold.
REQ-029 An execute with `instr_valid`=0 SHALL be ignored entirely: no state changes.
REQ-030 If `fetch`=1 and `execute`=1 in the same cycle, neither is accepted, all state holds, and `protocol_err` <= 1, sticky until reset.
REQ-031 With `fetch`=0 and `execute`=0, all state SHALL hold.
REQ-032 A fetch on a cycle after a jump SHALL read from the new `pc`, i.e. from `a_reg[14:0]`.

Reset
REQ-033 When `rst`=1 at a rising edge, the following SHALL clear, with `rst` taking priority over all strobes: `pc`=0, IR=0x0000, `instr_valid`=0, `jump_taken`=0, `halted`=0, `protocol_err`=0, `instr_count`=0.
REQ-034 Reset asserted between a fetch and its execute SHALL discard the fetched word; the next execute is ignored until a new fetch occurs.

Verification
REQ-035 Straight-line run: after reset, alternate fetch/execute with ROM words 0x0005, 0xEC10 and `zr`=`ng`=0 for 2 instructions -> IR follows ROM, `pc` goes 0→1→2, `instr_count`=2, `jump_taken`=0.
REQ-036 Conditional jump: IR=0xE302 (JEQ), `a_reg`=0x0040, `zr`=1 -> `pc`=0x0040, `jump_taken`=1; repeat with `zr`=0 -> `pc`+1, `jump_taken`=0.
REQ-037 Wrap and target mask: `pc`=0x7FFF with a non-jump -> `pc`=0x0000; IR=0xE307 (JMP) with `a_reg`=0x8012 -> `pc`=0x0012.
REQ-038 Halt: `pc`=0x000A, IR=0xEA87 (0;JMP), `a_reg`=0x000A -> `halted`=1, `instr_count` +1; subsequent strobes change nothing.
REQ-039 Protocol errors: `fetch`=`execute`=1 -> `protocol_err`=1 with all state held; execute directly after reset -> `pc`=0 and `instr_count`=0 unchanged.
REQ-040 Mid-operation reset: fetch 0xE307, assert `rst` for one cycle, then execute -> `instr_valid`=0, `pc`=0, no retirement.

Source files
------------

// File: rtl/hack_fetch_unit.sv
// rtl/hack_fetch_unit.sv - Hack CPU fetch/execute sequencer: PC, instruction register, jump decision, halt detect.
module hack_fetch_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch,
  input  logic        execute,
  input  logic [15:0] rom_data,
  input  logic [15:0] a_reg,
  input  logic        zr,
  input  logic        ng,
  output logic [14:0] rom_addr,
  output logic [15:0] instr,
  output logic        instr_valid,
  output logic        jump_taken,
  output logic        halted,
  output logic        protocol_err,
  output logic [15:0] instr_count
);

  logic [14:0] pc;
  logic [15:0] ir;
  logic        ir_valid;
  logic        jump_q;
  logic        halt_q;
  logic        perr_q;
  logic [15:0] count_q;

  logic        strobe_clash;
  logic        fetch_ok;
  logic        exec_ok;
  logic        take;
  logic [14:0] target;
  logic [14:0] next_pc;
  logic        self_jump;

  assign strobe_clash = fetch & execute;
  assign fetch_ok     = fetch & ~execute & ~halt_q;
  assign exec_ok      = execute & ~fetch & ~halt_q & ir_valid;

  // A-instructions (ir[15]=0) never branch; C-instructions test the ALU flags against j1..j3.
  assign take      = ir[15] & ((ir[2] & ng) | (ir[1] & zr) | (ir[0] & ~ng & ~zr));
  assign target    = a_reg[14:0];
  assign next_pc   = take ? target : pc + 15'd1;
  assign self_jump = take & (target == pc);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= 15'd0;
      ir       <= 16'h0000;
      ir_valid <= 1'b0;
      jump_q   <= 1'b0;
      halt_q   <= 1'b0;
      perr_q   <= 1'b0;
      count_q  <= 16'd0;
    end else begin
      if (strobe_clash) begin
        perr_q <= 1'b1;
      end
      if (fetch_ok) begin
        ir       <= rom_data;
        ir_valid <= 1'b1;
      end
      if (exec_ok) begin
        pc      <= next_pc;
        jump_q  <= take;
        count_q <= count_q + 16'd1;
        if (self_jump) begin
          halt_q <= 1'b1;
        end
      end
    end
  end

  assign rom_addr     = pc;
  assign instr        = ir;
  assign instr_valid  = ir_valid;
  assign jump_taken   = jump_q;
  assign halted       = halt_q;
  assign protocol_err = perr_q;
  assign instr_count  = count_q;

endmodule

// File: tb/tb_hack_fetch_unit.sv
// tb/tb_hack_fetch_unit.sv - Directed vector bench for hack_fetch_unit.
module tb_hack_fetch_unit;

  logic        clk;
  logic        rst;
  logic        fetch;
  logic        execute;
  logic [15:0] rom_data;
  logic [15:0] a_reg;
  logic        zr;
  logic        ng;
  logic [14:0] rom_addr;
  logic [15:0] instr;
  logic        instr_valid;
  logic        jump_taken;
  logic        halted;
  logic        protocol_err;
  logic [15:0] instr_count;

  int checks = 0;
  int failures = 0;

  hack_fetch_unit dut (
    .clk(clk),
    .rst(rst),
    .fetch(fetch),
    .execute(execute),
    .rom_data(rom_data),
    .a_reg(a_reg),
    .zr(zr),
    .ng(ng),
    .rom_addr(rom_addr),
    .instr(instr),
    .instr_valid(instr_valid),
    .jump_taken(jump_taken),
    .halted(halted),
    .protocol_err(protocol_err),
    .instr_count(instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        fetch;
    logic        execute;
    logic [15:0] rom_data;
    logic [15:0] a_reg;
    logic        zr;
    logic        ng;
    logic [14:0] exp_pc;
    logic [15:0] exp_ir;
    logic        exp_valid;
    logic        exp_jump;
    logic        exp_halt;
    logic        exp_perr;
    logic [15:0] exp_count;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic f, input logic e, input logic [15:0] rd,
                     input logic [15:0] a, input logic z, input logic n,
                     input logic [14:0] p, input logic [15:0] ir, input logic v,
                     input logic j, input logic h, input logic pe, input logic [15:0] c);
    vec_t t;
    t.rst = r; t.fetch = f; t.execute = e; t.rom_data = rd; t.a_reg = a; t.zr = z; t.ng = n;
    t.exp_pc = p; t.exp_ir = ir; t.exp_valid = v; t.exp_jump = j; t.exp_halt = h;
    t.exp_perr = pe; t.exp_count = c;
    vecs.push_back(t);
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic f, input logic e, input logic [15:0] rd,
                      input logic [15:0] a, input logic z, input logic n);
    @(negedge clk);
    rst = r; fetch = f; execute = e; rom_data = rd; a_reg = a; zr = z; ng = n;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; fetch = 1'b0; execute = 1'b0; rom_data = 16'h0; a_reg = 16'h0; zr = 1'b0; ng = 1'b0;

    //   rst f e  rom       a_reg     zr ng | pc        ir        v j h pe count
    add(1, 0, 0, 16'h0000, 16'h0000, 0, 0, 15'h0000, 16'h0000, 0, 0, 0, 0, 16'd0);
    add(0, 1, 0, 16'h0005, 16'h0000, 0, 0, 15'h0000, 16'h0005, 1, 0, 0, 0, 16'd0);
    add(0, 0, 1, 16'h0000, 16'h0001, 0, 0, 15'h0001, 16'h0005, 1, 0, 0, 0, 16'd1);
    add(0, 1, 0, 16'hEC10, 16'h0001, 0, 0, 15'h0001, 16'hEC10, 1, 0, 0, 0, 16'd1);
    add(0, 0, 1, 16'h0000, 16'h0001, 0, 0, 15'h0002, 16'hEC10, 1, 0, 0, 0, 16'd2);
    add(0, 1, 0, 16'hE302, 16'h0040, 0, 0, 15'h0002, 16'hE302, 1, 0, 0, 0, 16'd2);
    add(0, 0, 1, 16'h0000, 16'h0040, 1, 0, 15'h0040, 16'hE302, 1, 1, 0, 0, 16'd3);
    add(0, 1, 0, 16'hE302, 16'h0040, 0, 0, 15'h0040, 16'hE302, 1, 1, 0, 0, 16'd3);
    add(0, 0, 1, 16'h0000, 16'h0040, 0, 0, 15'h0041, 16'hE302, 1, 0, 0, 0, 16'd4);
    add(0, 1, 0, 16'hE307, 16'h7FFF, 0, 0, 15'h0041, 16'hE307, 1, 0, 0, 0, 16'd4);
    add(0, 0, 1, 16'h0000, 16'h7FFF, 0, 0, 15'h7FFF, 16'hE307, 1, 1, 0, 0, 16'd5);
    add(0, 1, 0, 16'hEC10, 16'h0003, 0, 0, 15'h7FFF, 16'hEC10, 1, 1, 0, 0, 16'd5);
    add(0, 0, 1, 16'h0000, 16'h0003, 0, 0, 15'h0000, 16'hEC10, 1, 0, 0, 0, 16'd6);
    add(0, 1, 0, 16'hE307, 16'h8012, 0, 0, 15'h0000, 16'hE307, 1, 0, 0, 0, 16'd6);
    add(0, 0, 1, 16'h0000, 16'h8012, 0, 0, 15'h0012, 16'hE307, 1, 1, 0, 0, 16'd7);
    add(0, 1, 0, 16'hE304, 16'h0020, 0, 1, 15'h0012, 16'hE304, 1, 1, 0, 0, 16'd7);
    add(0, 0, 1, 16'h0000, 16'h0020, 0, 1, 15'h0020, 16'hE304, 1, 1, 0, 0, 16'd8);
    add(0, 1, 1, 16'h1234, 16'h0055, 1, 0, 15'h0020, 16'hE304, 1, 1, 0, 1, 16'd8);
    add(0, 0, 0, 16'h1234, 16'h0055, 1, 0, 15'h0020, 16'hE304, 1, 1, 0, 1, 16'd8);
    add(1, 1, 1, 16'h1234, 16'h0055, 0, 0, 15'h0000, 16'h0000, 0, 0, 0, 0, 16'd0);
    add(0, 0, 1, 16'h0000, 16'h0005, 0, 0, 15'h0000, 16'h0000, 0, 0, 0, 0, 16'd0);
    add(0, 1, 0, 16'hE307, 16'h0005, 0, 0, 15'h0000, 16'hE307, 1, 0, 0, 0, 16'd0);
    add(1, 0, 0, 16'h0000, 16'h0005, 0, 0, 15'h0000, 16'h0000, 0, 0, 0, 0, 16'd0);
    add(0, 0, 1, 16'h0000, 16'h0005, 0, 0, 15'h0000, 16'h0000, 0, 0, 0, 0, 16'd0);
    add(0, 1, 0, 16'hE307, 16'h000A, 0, 0, 15'h0000, 16'hE307, 1, 0, 0, 0, 16'd0);
    add(0, 0, 1, 16'h0000, 16'h000A, 0, 0, 15'h000A, 16'hE307, 1, 1, 0, 0, 16'd1);
    add(0, 1, 0, 16'hEA87, 16'h000A, 0, 0, 15'h000A, 16'hEA87, 1, 1, 0, 0, 16'd1);
    add(0, 0, 1, 16'h0000, 16'h000A, 1, 0, 15'h000A, 16'hEA87, 1, 1, 1, 0, 16'd2);
    add(0, 1, 0, 16'h0000, 16'h0000, 0, 0, 15'h000A, 16'hEA87, 1, 1, 1, 0, 16'd2);
    add(0, 0, 1, 16'h0000, 16'h0033, 0, 1, 15'h000A, 16'hEA87, 1, 1, 1, 0, 16'd2);

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].fetch, vecs[i].execute, vecs[i].rom_data,
           vecs[i].a_reg, vecs[i].zr, vecs[i].ng);
      chk($sformatf("v%0d_pc", i), {1'b0, rom_addr}, {1'b0, vecs[i].exp_pc});
      chk($sformatf("v%0d_ir", i), instr, vecs[i].exp_ir);
      chk($sformatf("v%0d_valid", i), {15'd0, instr_valid}, {15'd0, vecs[i].exp_valid});
      chk($sformatf("v%0d_jump", i), {15'd0, jump_taken}, {15'd0, vecs[i].exp_jump});
      chk($sformatf("v%0d_halt", i), {15'd0, halted}, {15'd0, vecs[i].exp_halt});
      chk($sformatf("v%0d_perr", i), {15'd0, protocol_err}, {15'd0, vecs[i].exp_perr});
      chk($sformatf("v%0d_count", i), instr_count, vecs[i].exp_count);
    end

    // Reset releases halt; a fetch after a jump must see rom_addr at the new target immediately.
    step(1, 0, 0, 16'h0000, 16'h0000, 0, 0);
    chk("seq_halt_clear", {15'd0, halted}, 16'd0);
    step(0, 1, 0, 16'hE301, 16'h1234, 0, 0);
    step(0, 0, 1, 16'h0000, 16'h1234, 0, 0);
    chk("seq_jgt_addr", {1'b0, rom_addr}, 16'h1234);
    chk("seq_jgt_taken", {15'd0, jump_taken}, 16'd1);
    // Repeated executes without refetch re-retire the same IR; JGT falls through when ng=1.
    for (int k = 0; k < 4; k++) begin
      step(0, 0, 1, 16'h0000, 16'h1234, 0, 1);
    end
    chk("seq_repeat_addr", {1'b0, rom_addr}, 16'h1238);
    chk("seq_repeat_count", instr_count, 16'd5);
    chk("seq_repeat_jump", {15'd0, jump_taken}, 16'd0);
    // Clash stays sticky across idle cycles and leaves pc/count alone.
    step(0, 1, 1, 16'hFFFF, 16'h0000, 1, 1);
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 0, 16'h0000, 16'h0000, 0, 0);
    end
    chk("seq_perr_sticky", {15'd0, protocol_err}, 16'd1);
    chk("seq_perr_count", instr_count, 16'd5);
    chk("seq_perr_ir", instr, 16'hE301);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
